// File: rtl/uid_table_server_pkg.sv
// -----------------------------------------------------------------------------
// uid_table_server_pkg
// Shared constants, types and helpers for the UID table server slice.
//   - UID values: end-of-list sentinel, guest UID, second default UID
//   - table geometry and read-port latency
//   - enroll_err result codes and enrollment FSM state encoding
//   - default_entry(): power-on / reset content of each table slot
// -----------------------------------------------------------------------------
package uid_table_server_pkg;

  localparam logic [15:0] UID_SENTINEL = 16'hFFFF;
  localparam logic [15:0] GUEST_UID    = 16'h0000;
  localparam logic [15:0] DEFAULT_UID1 = 16'h9989;

  localparam int TABLE_DEPTH  = 32;
  localparam int READ_LATENCY = 2;
  localparam int ADDR_W       = 5;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [15:0]       uid_t;

  typedef enum logic [1:0] {
    ERR_OK   = 2'b00,
    ERR_DUP  = 2'b01,
    ERR_FULL = 2'b10,
    ERR_RSVD = 2'b11
  } err_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D1     = 3'd1,
    D2     = 3'd2,
    D3     = 3'd3,
    D4     = 3'd4,
    SCAN   = 3'd5,
    WRITE  = 3'd6,
    FINISH = 3'd7
  } state_t;

  // Reset content: guest in slot 0, one pre-enrolled user in slot 1,
  // everything else is the end-of-list sentinel.
  function automatic uid_t default_entry(input int idx);
    if (idx == 0)      return GUEST_UID;
    else if (idx == 1) return DEFAULT_UID1;
    else               return UID_SENTINEL;
  endfunction

endpackage

// File: rtl/uid_table_server_if.sv
// -----------------------------------------------------------------------------
// uid_table_server_if
// Bundles the lookup port and the enrollment handshake of uid_table_server.
//   slave  : seen by the server (lookup address and enrollment controls in,
//            lookup data and enrollment status out)
//   master : seen by the ID checker / keypad side driving the server
// -----------------------------------------------------------------------------
interface uid_table_server_if;
  import uid_table_server_pkg::*;

  logic [4:0]  addr_UID_ROM;
  logic [15:0] q_UID_ROM;
  logic        enroll_start;
  logic [3:0]  pwdigit;
  logic        pwenter;
  logic        enroll_abort;
  logic        enroll_busy;
  logic        enroll_done;
  logic [1:0]  enroll_err;
  logic [4:0]  enroll_slot;

  modport slave (
    input  addr_UID_ROM, enroll_start, pwdigit, pwenter, enroll_abort,
    output q_UID_ROM, enroll_busy, enroll_done, enroll_err, enroll_slot
  );

  modport master (
    output addr_UID_ROM, enroll_start, pwdigit, pwenter, enroll_abort,
    input  q_UID_ROM, enroll_busy, enroll_done, enroll_err, enroll_slot
  );

endinterface

// File: rtl/uid_table_mem.sv
// -----------------------------------------------------------------------------
// uid_table_mem
// 32 x 16-bit UID register table.
//   clk, rst   : clock, asynchronous active-high reset (restores defaults)
//   rd_addr    : pipelined lookup address, one per cycle
//   rd_data    : table[rd_addr] two register stages later
//   wr_en/wr_addr/wr_data : single write port (slot 31 is never written)
//   scan_addr/scan_data   : combinational read port for the enrollment scan
// -----------------------------------------------------------------------------
module uid_table_mem
  import uid_table_server_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  addr_t rd_addr,
  output uid_t  rd_data,
  input  logic  wr_en,
  input  addr_t wr_addr,
  input  uid_t  wr_data,
  input  addr_t scan_addr,
  output uid_t  scan_data
);

  localparam addr_t LAST_IDX = addr_t'(TABLE_DEPTH - 1);

  uid_t tbl     [TABLE_DEPTH];
  uid_t rd_pipe [READ_LATENCY];

  // Table storage. The last slot is the permanent end-of-list marker, so a
  // write aimed at it is dropped rather than trusting the caller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        tbl[i] <= default_entry(i);
      end
    end else if (wr_en && (wr_addr != LAST_IDX)) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  // Read pipeline. The first stage samples the array on the same edge a
  // write commits, so a same-cycle read sees the pre-write value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        rd_pipe[i] <= '0;
      end
    end else begin
      rd_pipe[0] <= tbl[rd_addr];
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  assign rd_data   = rd_pipe[READ_LATENCY-1];
  assign scan_data = tbl[scan_addr];

endmodule

// File: rtl/uid_table_server.sv
// -----------------------------------------------------------------------------
// uid_table_server
// UID lookup table with a keypad-driven enrollment FSM.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : uid_table_server_if.slave
//              lookup  : addr_UID_ROM -> q_UID_ROM (2-cycle pipelined read)
//              enroll  : enroll_start, pwdigit/pwenter (4 digits, MSB first),
//                        enroll_abort -> enroll_busy, enroll_done,
//                        enroll_err, enroll_slot
// -----------------------------------------------------------------------------
module uid_table_server
  import uid_table_server_pkg::*;
(
  input  logic clk,
  input  logic rst,
  uid_table_server_if.slave bus
);

  localparam addr_t LAST_IDX = addr_t'(TABLE_DEPTH - 1);

  state_t state_q, state_d;
  uid_t   uid_q, uid_d;
  addr_t  scan_idx_q, scan_idx_d;
  addr_t  rec_q, rec_d;
  addr_t  slot_q, slot_d;
  err_t   err_q, err_d;
  logic   wr_en;
  uid_t   scan_data;
  uid_t   full_uid;

  uid_table_mem u_mem (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (bus.addr_UID_ROM),
    .rd_data   (bus.q_UID_ROM),
    .wr_en     (wr_en),
    .wr_addr   (rec_q),
    .wr_data   (uid_q),
    .scan_addr (scan_idx_q),
    .scan_data (scan_data)
  );

  // UID as it will look once the fourth digit lands; used to catch the
  // reserved value before any scanning starts.
  assign full_uid = {uid_q[15:4], bus.pwdigit};

  // State and enrollment data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      uid_q      <= '0;
      scan_idx_q <= '0;
      rec_q      <= '0;
      slot_q     <= '0;
      err_q      <= ERR_OK;
    end else begin
      state_q    <= state_d;
      uid_q      <= uid_d;
      scan_idx_q <= scan_idx_d;
      rec_q      <= rec_d;
      slot_q     <= slot_d;
      err_q      <= err_d;
    end
  end

  // Enrollment sequencing. Abort is tested before pwenter in every digit and
  // scan state so it wins when both arrive together; WRITE and FINISH do not
  // look at abort, so a started write always completes. The scan walks the
  // list from slot 0: a matching entry is a duplicate, the first sentinel is
  // the append point, and reaching the permanent sentinel in the last slot
  // means the list is full.
  always_comb begin
    state_d    = state_q;
    uid_d      = uid_q;
    scan_idx_d = scan_idx_q;
    rec_d      = rec_q;
    slot_d     = slot_q;
    err_d      = err_q;
    wr_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.enroll_start) begin
          state_d = D1;
          err_d   = ERR_OK;
          uid_d   = '0;
        end
      end
      D1: begin
        if (bus.enroll_abort) begin
          state_d = IDLE;
        end else if (bus.pwenter) begin
          uid_d[15:12] = bus.pwdigit;
          state_d      = D2;
        end
      end
      D2: begin
        if (bus.enroll_abort) begin
          state_d = IDLE;
        end else if (bus.pwenter) begin
          uid_d[11:8] = bus.pwdigit;
          state_d     = D3;
        end
      end
      D3: begin
        if (bus.enroll_abort) begin
          state_d = IDLE;
        end else if (bus.pwenter) begin
          uid_d[7:4] = bus.pwdigit;
          state_d    = D4;
        end
      end
      D4: begin
        if (bus.enroll_abort) begin
          state_d = IDLE;
        end else if (bus.pwenter) begin
          uid_d[3:0] = bus.pwdigit;
          if (full_uid == UID_SENTINEL) begin
            err_d   = ERR_RSVD;
            state_d = FINISH;
          end else begin
            scan_idx_d = '0;
            state_d    = SCAN;
          end
        end
      end
      SCAN: begin
        if (bus.enroll_abort) begin
          state_d = IDLE;
        end else if (scan_data == uid_q) begin
          err_d   = ERR_DUP;
          state_d = FINISH;
        end else if (scan_data == UID_SENTINEL) begin
          if (scan_idx_q == LAST_IDX) begin
            err_d   = ERR_FULL;
            state_d = FINISH;
          end else begin
            rec_d   = scan_idx_q;
            state_d = WRITE;
          end
        end else begin
          scan_idx_d = scan_idx_q + addr_t'(1);
        end
      end
      WRITE: begin
        wr_en   = 1'b1;
        slot_d  = rec_q;
        state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Busy covers digit entry through the write; FINISH is the one-cycle
  // result cycle and is already reported as not busy.
  assign bus.enroll_busy = (state_q != IDLE) && (state_q != FINISH);
  assign bus.enroll_done = (state_q == FINISH) && (err_q == ERR_OK);
  assign bus.enroll_err  = err_q;
  assign bus.enroll_slot = slot_q;

endmodule

// File: tb/tb_uid_table_server.sv
// -----------------------------------------------------------------------------
// tb_uid_table_server
// Self-checking bench for uid_table_server. A behavioural model of the table
// (a plain array treated as an append-only list) predicts every enrollment
// outcome, its scan time and the table contents read back via the lookup port.
// -----------------------------------------------------------------------------
module tb_uid_table_server;
  import uid_table_server_pkg::*;

  logic clk = 1'b0;
  logic rst;

  uid_table_server_if bus ();

  uid_table_server dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mdl [TABLE_DEPTH];

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void modelReset();
    for (int i = 0; i < TABLE_DEPTH; i++) mdl[i] = UID_SENTINEL;
    mdl[0] = 16'h0000;
    mdl[1] = 16'h9989;
  endfunction

  // Number of enrolled entries ahead of the end-of-list marker.
  function automatic int modelLen();
    int n = 0;
    while (n < TABLE_DEPTH && mdl[n] != UID_SENTINEL) n++;
    return n;
  endfunction

  function automatic bit inModel(input logic [15:0] uid);
    for (int i = 0; i < modelLen(); i++) if (mdl[i] == uid) return 1'b1;
    return 1'b0;
  endfunction

  // Outcome of enrolling uid against the current list. Latency counts clock
  // edges from the fourth-digit edge to the edge that enters the result cycle:
  // one scan cycle per examined entry, plus one write cycle on success.
  task automatic predict(input logic [15:0] uid, output err_t e,
                         output int slot, output int lat);
    int len = modelLen();
    int pos = -1;
    for (int i = len - 1; i >= 0; i--) if (mdl[i] == uid) pos = i;
    slot = 0;
    if (uid == UID_SENTINEL) begin
      e = ERR_RSVD; lat = 0;
    end else if (pos >= 0) begin
      e = ERR_DUP; lat = pos + 1;
    end else if (len == TABLE_DEPTH - 1) begin
      e = ERR_FULL; lat = TABLE_DEPTH;
    end else begin
      e = ERR_OK; slot = len; lat = len + 2;
    end
  endtask

  // Stream all 32 addresses through the lookup port, one per cycle, and
  // compare each result two cycles after its address was presented.
  task automatic checkTable(input string tag);
    for (int c = 0; c < TABLE_DEPTH + 2; c++) begin
      if (c >= 2)
        checkOutput($sformatf("%s_rd%0d", tag, c - 2), 32'(bus.q_UID_ROM),
                    32'(mdl[c-2]));
      if (c < TABLE_DEPTH) bus.addr_UID_ROM = 5'(c);
      tick();
    end
  endtask

  // One enrollment attempt. abort_at 0..3 aborts together with that digit,
  // 4 aborts in the first scan cycle, anything else runs to completion.
  // Stray pwenter in idle and stray enroll_start while busy are mixed in.
  task automatic applyStimulus(input logic [15:0] uid, input int abort_at);
    err_t exp_err;
    int   exp_slot, exp_lat, lat;
    predict(uid, exp_err, exp_slot, exp_lat);

    bus.pwdigit = 4'($urandom);
    bus.pwenter = 1'b1;
    tick();
    bus.pwenter = 1'b0;

    bus.enroll_start = 1'b1;
    tick();
    bus.enroll_start = 1'b0;
    checkOutput("busy_after_start", 32'(bus.enroll_busy), 32'd1);
    checkOutput("err_cleared", 32'(bus.enroll_err), 32'(ERR_OK));

    for (int d = 0; d < 4; d++) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.enroll_start = 1'($urandom_range(0, 1));
        tick();
        bus.enroll_start = 1'b0;
      end
      bus.pwdigit = uid[15-4*d -: 4];
      bus.pwenter = 1'b1;
      bus.enroll_abort = (abort_at == d);
      tick();
      bus.pwenter = 1'b0;
      bus.enroll_abort = 1'b0;
      if (abort_at == d) begin
        checkOutput("abort_busy", 32'(bus.enroll_busy), 32'd0);
        checkOutput("abort_done", 32'(bus.enroll_done), 32'd0);
        checkOutput("abort_err", 32'(bus.enroll_err), 32'(ERR_OK));
        return;
      end
    end

    if (abort_at == 4 && exp_err != ERR_RSVD) begin
      bus.enroll_abort = 1'b1;
      tick();
      bus.enroll_abort = 1'b0;
      checkOutput("scan_abort_busy", 32'(bus.enroll_busy), 32'd0);
      checkOutput("scan_abort_done", 32'(bus.enroll_done), 32'd0);
      return;
    end

    lat = 0;
    while (bus.enroll_busy && lat < TABLE_DEPTH + 8) begin
      tick();
      lat++;
    end
    checkOutput("finish_latency", 32'(lat), 32'(exp_lat));
    checkOutput("finish_err", 32'(bus.enroll_err), 32'(exp_err));
    checkOutput("finish_done", 32'(bus.enroll_done), 32'(exp_err == ERR_OK));
    if (exp_err == ERR_OK) begin
      checkOutput("finish_slot", 32'(bus.enroll_slot), 32'(exp_slot));
      mdl[exp_slot] = uid;
    end
    tick();
    checkOutput("done_one_cycle", 32'(bus.enroll_done), 32'd0);
    checkOutput("err_held", 32'(bus.enroll_err), 32'(exp_err));
  endtask

  // Watchdog so a stuck design still produces a summary.
  initial begin
    #2000000;
    failures++;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [15:0] uid;
    int          tries;

    bus.addr_UID_ROM = '0;
    bus.enroll_start = 1'b0;
    bus.pwdigit      = '0;
    bus.pwenter      = 1'b0;
    bus.enroll_abort = 1'b0;
    modelReset();

    // Reset state, including a clock edge while reset is held.
    rst = 1'b1;
    #2;
    checkOutput("rst_q", 32'(bus.q_UID_ROM), 32'h0);
    checkOutput("rst_busy", 32'(bus.enroll_busy), 32'd0);
    checkOutput("rst_done", 32'(bus.enroll_done), 32'd0);
    checkOutput("rst_err", 32'(bus.enroll_err), 32'd0);
    checkOutput("rst_slot", 32'(bus.enroll_slot), 32'd0);
    bus.addr_UID_ROM = 5'd1;
    tick();
    tick();
    checkOutput("rst_q_clocked", 32'(bus.q_UID_ROM), 32'h0);
    rst = 1'b0;

    // Default contents: addresses 0,1,2 back to back then the rest.
    checkTable("boot");

    // First enrollment while the lookup address sits on the target slot:
    // the read sampled on the write edge still returns the old value.
    bus.addr_UID_ROM = 5'd2;
    applyStimulus(16'h1234, -1);
    checkOutput("rbw_old", 32'(bus.q_UID_ROM), 32'hFFFF);
    tick();
    checkOutput("rbw_new", 32'(bus.q_UID_ROM), 32'h1234);
    checkTable("after_1234");

    applyStimulus(16'h9989, -1);
    checkTable("after_dup");
    applyStimulus(16'hFFFF, -1);
    applyStimulus(16'h5678, 2);
    checkTable("after_abort");

    // Random mix of new, duplicate, reserved and aborted enrollments.
    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 7))
        0, 1:    uid = mdl[$urandom_range(0, modelLen() - 1)];
        2:       uid = 16'hFFFF;
        default: uid = 16'($urandom);
      endcase
      applyStimulus(uid, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1);
      checkTable($sformatf("rand%0d", n));
    end

    // Fill the remaining slots, then one more must report a full table.
    tries = 0;
    while (modelLen() < TABLE_DEPTH - 1 && tries < 200) begin
      applyStimulus(16'($urandom), -1);
      tries++;
    end
    checkOutput("fill_reached", 32'(modelLen()), 32'(TABLE_DEPTH - 1));
    uid = 16'h7777;
    while (inModel(uid)) uid = uid + 16'd1;
    applyStimulus(uid, -1);
    checkTable("full");

    // Reset in the middle of a scan restores defaults immediately.
    bus.enroll_start = 1'b1;
    tick();
    bus.enroll_start = 1'b0;
    for (int d = 0; d < 4; d++) begin
      bus.pwdigit = 4'(d + 3);
      bus.pwenter = 1'b1;
      tick();
    end
    bus.pwenter = 1'b0;
    tick();
    checkOutput("pre_rst_busy", 32'(bus.enroll_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midscan_rst_busy", 32'(bus.enroll_busy), 32'd0);
    checkOutput("midscan_rst_q", 32'(bus.q_UID_ROM), 32'h0);
    checkOutput("midscan_rst_slot", 32'(bus.enroll_slot), 32'd0);
    checkOutput("midscan_rst_err", 32'(bus.enroll_err), 32'd0);
    tick();
    rst = 1'b0;
    modelReset();
    checkTable("post_reset");
    applyStimulus(16'hBEEF, -1);
    checkTable("post_reset_enroll");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
